// File: rtl/wb_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_pkg
// Description : Shared widths and writeback source encodings for the
//               writeback stage. The control unit and the EX forwarding path
//               import the same codes.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_regfile_pkg;

    localparam int c_WORD_WIDTH     = 32;
    localparam int c_REG_SIZE       = 5;
    localparam int c_REG_SRC_LENGTH = 2;
    localparam logic [c_WORD_WIDTH-1:0] c_ZERO_WORD = '0;

    // Writeback source codes. Code 2'b11 is reserved and behaves as ALU.
    typedef enum logic [c_REG_SRC_LENGTH-1:0] {
        REG_SRC_ALU  = 2'b00,
        REG_SRC_MEM  = 2'b01,
        REG_SRC_LINK = 2'b10,
        REG_SRC_RSVD = 2'b11
    } reg_src_e;

endpackage : wb_regfile_pkg
`default_nettype wire

// File: rtl/wb_mux.sv
`default_nettype none
// ============================================================================
// Module      : wb_mux
// Description : 4:1 writeback source select. Purely combinational; also
//               used by the EX forwarding path.
// Ports       : sel        - source select (reg_src_e encoding)
//               alu_out    - ALU result
//               read_data  - load data (already extended)
//               link_addr  - return address for link instructions
//               wb_data    - selected writeback value
// Revision    : 1.0 - initial release
// ============================================================================
module wb_mux
    import wb_regfile_pkg::*;
(
    input  logic [c_REG_SRC_LENGTH-1:0] sel,
    input  logic [c_WORD_WIDTH-1:0]     alu_out,
    input  logic [c_WORD_WIDTH-1:0]     read_data,
    input  logic [c_WORD_WIDTH-1:0]     link_addr,
    output logic [c_WORD_WIDTH-1:0]     wb_data
);

    always_comb begin
        wb_data = alu_out;
        case (reg_src_e'(sel))
            REG_SRC_ALU:  wb_data = alu_out;
            REG_SRC_MEM:  wb_data = read_data;
            REG_SRC_LINK: wb_data = link_addr;
            default:      wb_data = alu_out;  // reserved code
        endcase
    end

endmodule : wb_mux
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : Writeback stage. Selects the writeback value, commits it to
//               the general-purpose register file and serves two decode read
//               ports with write-first bypass. Keeps a committed-write count.
// Ports       : clk, rst (async, active low)
//               Regfile_weW, regSrc_muxW, aluOutW, readDataW, linkAddrW,
//               writeRegAddrW   - MEM/WB fields
//               rsAddrD/rtAddrD - decode read addresses
//               rsDataD/rtDataD - decode read data (combinational)
//               wbDataW/wbValidW - writeback value/valid for forwarding
//               wbCount         - committed-write counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        Regfile_weW,
    input  logic [c_REG_SRC_LENGTH-1:0] regSrc_muxW,
    input  logic [c_WORD_WIDTH-1:0]     aluOutW,
    input  logic [c_WORD_WIDTH-1:0]     readDataW,
    input  logic [c_WORD_WIDTH-1:0]     linkAddrW,
    input  logic [c_REG_SIZE-1:0]       writeRegAddrW,
    input  logic [c_REG_SIZE-1:0]       rsAddrD,
    input  logic [c_REG_SIZE-1:0]       rtAddrD,
    output logic [c_WORD_WIDTH-1:0]     rsDataD,
    output logic [c_WORD_WIDTH-1:0]     rtDataD,
    output logic [c_WORD_WIDTH-1:0]     wbDataW,
    output logic                        wbValidW,
    output logic [CNT_WIDTH-1:0]        wbCount
);

    logic [c_WORD_WIDTH-1:0] regs_q [NUM_REGS];
    logic [c_WORD_WIDTH-1:0] regs_d [NUM_REGS];
    logic [CNT_WIDTH-1:0]    count_q;
    logic [CNT_WIDTH-1:0]    count_d;

    wb_mux u_wb_mux (
        .sel       (regSrc_muxW),
        .alu_out   (aluOutW),
        .read_data (readDataW),
        .link_addr (linkAddrW),
        .wb_data   (wbDataW)
    );

    // Register 0 is never a valid destination, so it is never written and
    // stays at its reset value of zero.
    assign wbValidW = Regfile_weW && (writeRegAddrW != '0);

    always_comb begin
        regs_d  = regs_q;
        count_d = count_q;
        if (wbValidW) begin
            regs_d[writeRegAddrW] = wbDataW;
            count_d               = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= c_ZERO_WORD;
            end
            count_q <= '0;
        end else begin
            regs_q  <= regs_d;
            count_q <= count_d;
        end
    end

    // Read port: zero for r0 and while reset is held (bypass included),
    // otherwise write-first bypass ahead of the stored value.
    function automatic logic [c_WORD_WIDTH-1:0] read_port(
        input logic                    in_reset,
        input logic [c_REG_SIZE-1:0]   addr,
        input logic                    wr_valid,
        input logic [c_REG_SIZE-1:0]   wr_addr,
        input logic [c_WORD_WIDTH-1:0] wr_data,
        input logic [c_WORD_WIDTH-1:0] stored
    );
        logic [c_WORD_WIDTH-1:0] data;
        data = stored;
        if (in_reset || (addr == '0)) begin
            data = c_ZERO_WORD;
        end else if (wr_valid && (addr == wr_addr)) begin
            data = wr_data;
        end
        return data;
    endfunction

    always_comb begin
        rsDataD = read_port(!rst, rsAddrD, wbValidW, writeRegAddrW, wbDataW,
                            regs_q[rsAddrD]);
        rtDataD = read_port(!rst, rtAddrD, wbValidW, writeRegAddrW, wbDataW,
                            regs_q[rtAddrD]);
    end

    assign wbCount = count_q;

endmodule : wb_regfile
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile
// Description : Self-checking bench for wb_regfile. Expected values are
//               queued when stimulus is applied and popped when the DUT
//               output is sampled. Counter width is 4 to exercise wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             we = 1'b0;
    logic [1:0]       src = 2'b00;
    logic [31:0]      alu = '0;
    logic [31:0]      mem = '0;
    logic [31:0]      link = '0;
    logic [4:0]       waddr = '0;
    logic [4:0]       rs_a = '0;
    logic [4:0]       rt_a = '0;
    logic [31:0]      rs_d;
    logic [31:0]      rt_d;
    logic [31:0]      wb_d;
    logic             wb_v;
    logic [CNT_W-1:0] wb_cnt;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [32];
    int          model_cnt = 0;

    wb_regfile #(.NUM_REGS(32), .CNT_WIDTH(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .Regfile_weW   (we),
        .regSrc_muxW   (src),
        .aluOutW       (alu),
        .readDataW     (mem),
        .linkAddrW     (link),
        .writeRegAddrW (waddr),
        .rsAddrD       (rs_a),
        .rtAddrD       (rt_a),
        .rsDataD       (rs_d),
        .rtDataD       (rt_d),
        .wbDataW       (wb_d),
        .wbValidW      (wb_v),
        .wbCount       (wb_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input string tag, input logic [31:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    function automatic logic [31:0] cnt32();
        return {{(32-CNT_W){1'b0}}, wb_cnt};
    endfunction

    // One commit cycle: inputs applied after a falling edge, the rising edge
    // commits, and the bench model follows.
    task automatic commit(input logic [4:0] a, input logic [31:0] v);
        @(negedge clk);
        we = 1'b1; src = 2'b00; alu = v; waddr = a;
        @(posedge clk);
        if (a != 5'd0) begin
            model[a] = v;
            model_cnt = (model_cnt + 1) % (1 << CNT_W);
        end
        #1 we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Reset held while a write is presented.
        we = 1'b1; waddr = 5'd5; alu = 32'hDEADBEEF; rs_a = 5'd5; rt_a = 5'd5;
        repeat (2) @(negedge clk);
        #2;
        push("rst_rs_during", 32'h0);  pop_check(rs_d);
        push("rst_rt_during", 32'h0);  pop_check(rt_d);
        push("rst_cnt_during", 32'h0); pop_check(cnt32());
        we = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #2;
        push("rst_r5_after", 32'h0);   pop_check(rs_d);
        push("rst_cnt_after", 32'h0);  pop_check(cnt32());

        // Source select.
        alu = 32'h11; mem = 32'h22; link = 32'h0040_0008;
        src = 2'b00; #1 push("src_alu", 32'h11);        pop_check(wb_d);
        src = 2'b01; #1 push("src_mem", 32'h22);        pop_check(wb_d);
        src = 2'b10; #1 push("src_link", 32'h0040_0008); pop_check(wb_d);
        src = 2'b11; #1 push("src_rsvd", 32'h11);       pop_check(wb_d);

        // Commit r8, read next cycle.
        commit(5'd8, 32'h1234_5678);
        rs_a = 5'd8; #1;
        push("commit_r8", model[8]);              pop_check(rs_d);
        push("commit_cnt", 32'(model_cnt));       pop_check(cnt32());

        // Bypass: both ports address the register being written.
        @(negedge clk);
        we = 1'b1; src = 2'b00; alu = 32'hCAFE_F00D; waddr = 5'd9;
        rs_a = 5'd9; rt_a = 5'd9; #2;
        push("byp_rs", 32'hCAFE_F00D);            pop_check(rs_d);
        push("byp_rt", 32'hCAFE_F00D);            pop_check(rt_d);
        push("byp_valid", 32'h1);                 pop_check({31'b0, wb_v});
        rs_a = 5'd8; #1;
        push("byp_other_port", 32'h1234_5678);    pop_check(rs_d);
        @(posedge clk);
        model[9] = 32'hCAFE_F00D;
        model_cnt = model_cnt + 1;
        #1 we = 1'b0;
        #2 push("r9_stored", model[9]);           pop_check(rt_d);

        // Register 0 write is discarded.
        @(negedge clk);
        we = 1'b1; alu = 32'hFFFF_FFFF; waddr = 5'd0; rs_a = 5'd0; rt_a = 5'd0; #2;
        push("r0_valid", 32'h0);                  pop_check({31'b0, wb_v});
        push("r0_bypass", 32'h0);                 pop_check(rs_d);
        @(posedge clk); #1 we = 1'b0; #1;
        push("r0_read", 32'h0);                   pop_check(rt_d);
        push("r0_cnt", 32'(model_cnt));           pop_check(cnt32());

        // Fill to 17 commits in total; 4-bit counter wraps to 1.
        for (int i = 0; i < 15; i++) commit(5'(10 + i), 32'h1000 * i + 32'h7);
        #1;
        push("wrap_cnt", 32'h1);                  pop_check(cnt32());
        rs_a = 5'd12; rt_a = 5'd24; #1;
        push("fill_r12", model[12]);              pop_check(rs_d);
        push("fill_r24", model[24]);              pop_check(rt_d);

        // Mid-run reset pulse between edges, with a write presented.
        @(negedge clk);
        we = 1'b1; alu = 32'h5555_AAAA; waddr = 5'd12; rs_a = 5'd12; rt_a = 5'd9;
        rst = 1'b0; #1;
        push("mid_rst_byp", 32'h0);               pop_check(rs_d);
        push("mid_rst_r9", 32'h0);                pop_check(rt_d);
        push("mid_rst_cnt", 32'h0);               pop_check(cnt32());
        we = 1'b0; #1 rst = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        model_cnt = 0;
        #1;
        push("post_rst_r12", 32'h0);              pop_check(rs_d);
        push("post_rst_r9", 32'h0);               pop_check(rt_d);

        // First commit after release lands on the first edge.
        commit(5'd3, 32'h0000_0ABC);
        rs_a = 5'd3; #1;
        push("first_commit_r3", model[3]);        pop_check(rs_d);
        push("first_commit_cnt", 32'(model_cnt)); pop_check(cnt32());

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_wb_regfile
`default_nettype wire

// File: doc/wb_regfile.md
# wb_regfile

Writeback-stage consumer of the MEM/WB pipeline register. It selects the writeback value from the W-stage fields (ALU result, load data, link address), commits it to a 32×32 general-purpose register file, and serves the two decode-stage read ports with same-cycle write bypass. It also exports the selected writeback value for the EX forwarding unit, and keeps a committed-write counter for debug.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired to zero.
- CNT_WIDTH, 32, width of the committed-write counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- Regfile_weW  in  1  writeback enable from MEM/WB.
- regSrc_muxW  in  `REG_SRC_LENGTH (2)  writeback source select.
- aluOutW  in  `WORD_WIDTH (32)  ALU result.
- readDataW  in  `WORD_WIDTH  load data.
- linkAddrW  in  `WORD_WIDTH  return address for link instructions (PC+8).
- writeRegAddrW  in  `REG_SIZE (5)  destination register.
- rsAddrD  in  5  decode read port A address.
- rtAddrD  in  5  decode read port B address.
- rsDataD  out  32  read port A data; combinational.
- rtDataD  out  32  read port B data; combinational.
- wbDataW  out  32  selected writeback value; combinational, feeds forwarding.
- wbValidW  out  1  high when Regfile_weW=1 and writeRegAddrW≠0.
- wbCount  out  CNT_WIDTH  number of committed writes.

## Operation
- Source select for wbDataW:
  - `REG_SRC_ALU (00): aluOutW.
  - `REG_SRC_MEM (01): readDataW.
  - `REG_SRC_LINK (10): linkAddrW.
  - 11: reserved; selects aluOutW.
- Commit:
  - Condition: at the rising clk edge with wbValidW=1.
  - Action: regs[writeRegAddrW] ← wbDataW.
  - Writes to register 0 are discarded.
- Read ports (each port independent):
  - Address 0 returns 0.
  - Else, if wbValidW=1 and the address equals writeRegAddrW, return wbDataW (write-first bypass).
  - Else return regs[addr].
- Counter:
  - wbCount increments by 1 on every commit.
  - Wraps modulo 2^CNT_WIDTH.
  - Holds when no commit occurs.
- Reset:
  - rst=0 asynchronously clears all registers and wbCount to 0.
  - During reset, read ports return 0 regardless of inputs.
  - Reset asserted in the same cycle as a write wins; nothing is committed.
- Width rules: no sign or zero extension here. Loads arrive already extended in readDataW.

## Timing
- Write latency: 1 cycle. The value is visible in regs after the edge, and visible via bypass during the cycle it is presented.
- Read latency: 0 cycles, purely combinational from address, regs and W-stage inputs.
- Both read ports may address the register being written in the same cycle; both return wbDataW.
- Rising edge with rst=1 after deassertion: normal operation resumes; the first commit is possible on the first edge.
- Reset values: rsDataD=0, rtDataD=0, wbCount=0. wbDataW and wbValidW follow their inputs combinationally; they are 0 when the MEM/WB register is held in reset.

## Structure
- Shared defines header (defines.vh) holds:
  - `WORD_WIDTH, `REG_SIZE, `REG_SRC_LENGTH, `ZERO_WORD (already present).
  - New `REG_SRC_ALU, `REG_SRC_MEM, `REG_SRC_LINK codes, so the control unit uses the same encodings.
- One sub-module, wb_mux: the 4:1 source select, also reused by the EX forwarding path.
- Register array and bypass compare live in wb_regfile.

## Test plan
- Reset: hold rst=0 while driving Regfile_weW=1, writeRegAddrW=5, aluOutW=0xDEADBEEF -> regs unchanged; rsDataD(addr 5)=0; wbCount=0 after release.
- Source select:
  - regSrc=00, aluOutW=0x11 -> wbDataW=0x11.
  - regSrc=01, readDataW=0x22 -> wbDataW=0x22.
  - regSrc=10, linkAddrW=0x400008 -> wbDataW=0x400008.
  - regSrc=11 -> wbDataW=0x11.
- Commit and read: write 0x12345678 to r8 -> next cycle rsAddrD=8 gives 0x12345678; wbCount=1.
- Bypass: same cycle, write 0xCAFEF00D to r9 with rsAddrD=rtAddrD=9 -> both ports return 0xCAFEF00D before the edge.
- Register 0: write 0xFFFFFFFF to r0 -> wbValidW=0; reads of r0 return 0; wbCount unchanged.
- Wrap and mid-run reset:
  - With CNT_WIDTH=4, 17 commits -> wbCount=1.
  - Pulse rst low between edges -> all registers and wbCount read 0 immediately.
